pdp11_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder and state sequencer (S1/S2 flow).
- Reads 16-bit words from instruction flash using a request/acknowledge handshake and tracks a byte-addressed PC (+2 per word).
- Buffers fetched words with their PC in a small prefetch FIFO and hands them to decode through a valid/ready handshake.
- Supports branch/jump redirect with flush, and raises an odd-address fault.

---
 rtl/pdp11_fetch_unit.sv | 118 +++++++++++
 tb/tb_pdp11_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp11_fetch_unit.sv
// PDP-11 instruction fetch stage: flash request/ack port, prefetch FIFO,
// redirect with flush, and sticky odd-address fault.
module pdp11_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'o000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        ins_valid,
    output logic [15:0] ins_word,
    output logic [15:0] ins_pc,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_FAULT   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   pc_q, pc_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   word_q [DEPTH];
    logic [15:0]   wpc_q  [DEPTH];

    logic outst, push, pop, faulted, issue;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // A request stays outstanding until acked, even across redirect or fault
        outst   = req_q & ~mem_ack;
        push    = req_q & mem_ack & (state_q == S_REQ) & ~redirect;
        pop     = (cnt_q != '0) & ins_ready & ~redirect;
        faulted = redirect ? redirect_pc[0] : (state_q == S_FAULT);

        if (redirect) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            pc_d  = redirect_pc;
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            rd_d  = pop ? nxt(rd_q) : rd_q;
            wr_d  = push ? nxt(wr_q) : wr_q;
            pc_d  = push ? addr_q + 16'd2 : pc_q;
        end

        // Issue decision looks at next-cycle occupancy so acks can stream
        issue  = ~faulted & ~outst & (cnt_d < FULL);
        req_d  = outst | issue;
        addr_d = issue ? pc_d : addr_q;

        if (faulted) begin
            state_d = S_FAULT;
        end else if (outst) begin
            state_d = redirect ? S_DISCARD : state_q;
        end else if (issue) begin
            state_d = S_REQ;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 16'd0;
                wpc_q[i]  <= 16'd0;
            end
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            if (push) begin
                word_q[wr_q] <= mem_rdata;
                wpc_q[wr_q]  <= addr_q;
            end
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign ins_valid   = (cnt_q != '0);
    assign ins_word    = word_q[rd_q];
    assign ins_pc      = wpc_q[rd_q];
    assign fetch_fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_pdp11_fetch_unit.sv
// Bench for pdp11_fetch_unit: flash responder, scoreboard of expected
// (pc, word) stream derived from redirect targets, directed and random runs.
module tb_pdp11_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        ins_valid;
    logic [15:0] ins_word;
    logic [15:0] ins_pc;
    logic        ins_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'd0;
    logic        fetch_fault;

    localparam logic [15:0] RPC = 16'o000000;

    pdp11_fetch_unit #(.DEPTH(2), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ins_valid(ins_valid), .ins_word(ins_word), .ins_pc(ins_pc),
        .ins_ready(ins_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int issues = 0;
    int pops   = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Reference model: after reset/redirect the decoder must see the
    // consecutive word addresses from the target, each with flash contents.
    logic [15:0] expq[$];
    logic [15:0] model_pc = 16'd0;
    bit          model_live = 1'b0;

    task automatic topup;
        while (model_live && expq.size() < 16) begin
            expq.push_back(model_pc);
            model_pc = model_pc + 16'd2;
        end
    endtask

    task automatic step;
        @(posedge clock);
        #2;
        topup();
    endtask

    // Flash responder
    bit flash_on    = 1'b1;
    bit stray_en    = 1'b0;
    int fixed_delay = 0;
    int stray_req   = 0;
    int stray_done  = 0;
    int wcnt        = -1;

    always @(posedge clock) begin
        #3;
        mem_ack = 1'b0;
        if (reset) begin
            wcnt = -1;
        end else if (!mem_req) begin
            if (stray_req > stray_done ||
                (stray_en && $urandom_range(0, 7) == 0)) begin
                if (stray_req > stray_done) stray_done++;
                mem_ack   = 1'b1;
                mem_rdata = 16'($urandom);
            end
        end else if (flash_on) begin
            if (wcnt < 0)
                wcnt = (fixed_delay >= 0) ? fixed_delay
                                          : int'($urandom_range(0, 3));
            if (wcnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = memf(mem_addr);
                wcnt      = -1;
            end else begin
                wcnt--;
            end
        end
    end

    // Monitor / scoreboard
    logic        p_req, p_ack, p_valid, p_ready, p_redir;
    logic [15:0] p_addr, p_word, p_pc, epc;
    bit          exp_fault;

    always @(negedge clock) begin
        if (reset) begin
            {p_req, p_ack, p_valid, p_ready, p_redir} = '0;
            exp_fault = 1'b0;
        end else begin
            chk("fault_flag", 32'(fetch_fault), 32'(exp_fault));
            if (mem_req) chk("addr_even", 32'(mem_addr[0]), 0);
            if (p_req && !p_ack) begin
                chk("req_hold", 32'(mem_req), 1);
                chk("addr_hold", 32'(mem_addr), 32'(p_addr));
            end else if (mem_req) begin
                issues++;
            end
            if (exp_fault && !(p_req && !p_ack))
                chk("fault_noreq", 32'(mem_req), 0);
            if (p_redir || exp_fault) begin
                chk("flush_valid", 32'(ins_valid), 0);
            end else if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(ins_valid), 1);
                chk("hold_word", 32'(ins_word), 32'(p_word));
                chk("hold_pc", 32'(ins_pc), 32'(p_pc));
            end
            if (ins_valid && ins_ready && !redirect) begin
                if (expq.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    epc = expq.pop_front();
                    chk("sb_pc", 32'(ins_pc), 32'(epc));
                    chk("sb_word", 32'(ins_word), 32'(memf(epc)));
                    pops++;
                end
            end
            if (redirect) exp_fault = redirect_pc[0];
            p_req   = mem_req;
            p_ack   = mem_ack;
            p_addr  = mem_addr;
            p_valid = ins_valid;
            p_ready = ins_ready;
            p_redir = redirect;
            p_word  = ins_word;
            p_pc    = ins_pc;
        end
    end

    task automatic do_reset;
        reset    = 1'b1;
        redirect = 1'b0;
        expq.delete();
        #1;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 32'(RPC));
        chk("rst_valid", 32'(ins_valid), 0);
        chk("rst_word", 32'(ins_word), 0);
        chk("rst_pc", 32'(ins_pc), 0);
        chk("rst_fault", 32'(fetch_fault), 0);
        model_pc   = RPC;
        model_live = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic redir(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        expq.delete();
        model_pc   = pc;
        model_live = !pc[0];
        topup();
        step();
        redirect = 1'b0;
    endtask

    int base;
    bit got;
    logic [15:0] tgt;

    initial begin
        #2;
        // Streaming from reset with immediate acks
        fixed_delay = 0;
        ins_ready   = 1'b1;
        do_reset();
        for (int k = 0; k < 10 && !ins_valid; k++) step();
        for (int j = 0; j < 4; j++) begin
            chk("stream_valid", 32'(ins_valid), 1);
            chk("stream_pc", 32'(ins_pc), 32'(2 * j));
            step();
        end

        // Backpressure fills the FIFO then stops fetching
        ins_ready = 1'b0;
        do_reset();
        issues = 0;
        repeat (10) step();
        chk("bp_issues", 32'(issues), 2);
        chk("bp_req_off", 32'(mem_req), 0);
        chk("bp_head_pc", 32'(ins_pc), 0);
        ins_ready = 1'b1;
        step();
        chk("bp_next_pc", 32'(ins_pc), 2);
        chk("bp_resume_req", 32'(mem_req), 1);
        chk("bp_resume_addr", 32'(mem_addr), 4);
        repeat (6) step();

        // Redirect during a slow ack discards the old data
        fixed_delay = 3;
        do_reset();
        for (int k = 0; k < 10 && !mem_req; k++) step();
        chk("dly_req", 32'(mem_req), 1);
        redir(16'o000100);
        fixed_delay = 0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (mem_ack) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("dly_ack_seen", 32'(got), 1);
        step();
        chk("dly_new_req", 32'(mem_req), 1);
        chk("dly_new_addr", 32'(mem_addr), 32'(16'o000100));
        repeat (6) step();

        // Odd redirect faults; even redirect recovers
        do_reset();
        repeat (5) step();
        redir(16'o000101);
        base = issues;
        repeat (20) step();
        chk("flt_noissue", 32'(issues - base), 0);
        chk("flt_flag", 32'(fetch_fault), 1);
        chk("flt_valid", 32'(ins_valid), 0);
        redir(16'o000200);
        chk("flt_clear", 32'(fetch_fault), 0);
        chk("flt_req", 32'(mem_req), 1);
        chk("flt_addr", 32'(mem_addr), 32'(16'o000200));
        repeat (6) step();

        // Address wrap at the top of memory
        redir(16'o177776);
        for (int k = 0; k < 10 && !ins_valid; k++) step();
        chk("wrap_pc0", 32'(ins_pc), 32'(16'o177776));
        step();
        chk("wrap_valid", 32'(ins_valid), 1);
        chk("wrap_pc1", 32'(ins_pc), 0);
        repeat (4) step();

        // Reset mid-transaction, then a stray ack right after release
        ins_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10 && !ins_valid; k++) step();
        flash_on = 1'b0;
        step();
        chk("mid_outst", 32'(mem_req), 1);
        chk("mid_valid", 32'(ins_valid), 1);
        do_reset();
        stray_req++;
        step();
        chk("rel_req", 32'(mem_req), 1);
        chk("rel_addr", 32'(mem_addr), 32'(RPC));
        chk("rel_valid", 32'(ins_valid), 0);
        flash_on  = 1'b1;
        ins_ready = 1'b1;
        step();
        chk("rel_first_valid", 32'(ins_valid), 1);
        chk("rel_first_word", 32'(ins_word), 32'(memf(RPC)));
        repeat (4) step();

        // Randomised traffic
        fixed_delay = -1;
        stray_en    = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ins_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                tgt = 16'($urandom);
                if ($urandom_range(0, 4) != 0) tgt[0] = 1'b0;
                redir(tgt);
            end else begin
                step();
            end
        end
        if (fetch_fault) redir(16'o001000);
        repeat (20) step();
        chk("progress", 32'(pops > 500), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
